// File: rtl/div_pkg.sv
// Shared definitions for the sequential 8-bit divider.
//   state_t       : divider FSM states (IDLE, CALC, FIX, DONE)
//   DIV_WIDTH     : default operand / quotient / remainder width
//   DIV_CNT_W     : width of the iteration counter ($clog2(WIDTH)+1)
//   DIV_FS_DIV    : FS code for signed divide
//   DIV_FS_DIVU   : FS code for unsigned divide
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  localparam logic [4:0] DIV_FS_DIV  = 5'h3;
  localparam logic [4:0] DIV_FS_DIVU = 5'h4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_8_step.sv
// One restoring shift-subtract step of the divider (purely combinational).
// Ports:
//   rem      in  : partial remainder (always < divisor on entry)
//   dvd      in  : dividend / quotient shift register
//   divisor  in  : divisor magnitude
//   rem_next out : partial remainder after this step
//   dvd_next out : dvd shifted left by one, LSB left at 0
//   q_bit    out : quotient bit produced by this step (caller inserts it)
module div_8_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next,
  output logic             q_bit
);

  // The shifted remainder needs one extra bit so the compare is exact.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    rem_sh   = {rem, dvd[WIDTH-1]};
    q_bit    = (rem_sh >= {1'b0, divisor});
    // Only used when rem_sh >= divisor, so the difference fits in WIDTH bits.
    diff     = rem_sh[WIDTH-1:0] - divisor;
    rem_next = q_bit ? diff : rem_sh[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/div_8_seq.sv
// Sequential 8-bit restoring divider (DIV / DIVU) feeding the HI/LO pair.
// Quotient goes to VY_lo, remainder to VY_hi. Quotient truncates toward
// zero; remainder takes the sign of the dividend.
// Optional build macro: DIV8_EARLY_OUT_EN -- when defined, a divide with
// |S| < |T| (T != 0) skips CALC/FIX and completes one edge after accept.
// Ports:
//   clk       in  : system clock, rising edge
//   reset     in  : asynchronous active-low reset
//   start     in  : divide request, sampled only in IDLE
//   S         in  : dividend
//   T         in  : divisor
//   FS        in  : function select (FS_DIV signed, FS_DIVU unsigned)
//   VY_hi     out : remainder (registered)
//   VY_lo     out : quotient (registered)
//   busy      out : high from the accept edge until the done cycle
//   done      out : one-cycle completion pulse
//   div0      out : divide-by-zero flag, set with done, cleared on accept
//   dbg_state out : current FSM state
// Handshake: a request is taken on a rising edge where the FSM is IDLE,
// start=1 and FS selects a divide; operands are latched on that edge and
// may change afterwards. No further request is taken until the FSM has
// returned to IDLE after the done cycle, so start held high or asserted
// while busy/done is simply ignored.
module div_8_seq
  import div_pkg::*;
#(
  parameter int         WIDTH   = DIV_WIDTH,
  parameter logic [4:0] FS_DIV  = DIV_FS_DIV,
  parameter logic [4:0] FS_DIVU = DIV_FS_DIVU
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  input  logic [4:0]       FS,
  output logic [WIDTH-1:0] VY_hi,
  output logic [WIDTH-1:0] VY_lo,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output state_t           dbg_state
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  state_t state, state_nxt;

  // Operation registers latched at accept
  logic             signed_q;
  logic             sign_q;     // negate quotient in FIX
  logic             sign_r;     // negate remainder in FIX
  logic             zero_q;     // divisor was zero
  logic [WIDTH-1:0] s_raw;      // raw dividend, used by the shortcut results
  logic [WIDTH-1:0] dvs;        // divisor magnitude
  logic [WIDTH-1:0] dvd;        // dividend magnitude, becomes the quotient
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] count;

  // Accept-time decode
  logic             is_div;
  logic             is_signed;
  logic             accept;
  logic             t_zero;
  logic             early;
  logic [WIDTH-1:0] s_mag;
  logic [WIDTH-1:0] t_mag;

  // Step outputs
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;
  logic             step_q;

  always_comb begin
    is_div    = (FS == FS_DIV) || (FS == FS_DIVU);
    is_signed = (FS == FS_DIV);
    accept    = (state == IDLE) && start && is_div;
    t_zero    = (T == '0);
    s_mag     = (is_signed && S[WIDTH-1]) ? (~S + ONE) : S;
    t_mag     = (is_signed && T[WIDTH-1]) ? (~T + ONE) : T;
`ifdef DIV8_EARLY_OUT_EN
    // Quotient is 0 and remainder is the raw dividend; no iteration needed.
    early     = !t_zero && (s_mag < t_mag);
`else
    early     = 1'b0;
`endif
  end

  div_8_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd      (dvd),
    .divisor  (dvs),
    .rem_next (step_rem),
    .dvd_next (step_dvd),
    .q_bit    (step_q)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. DONE is left once the done pulse has been issued:
  // after FIX the pulse is already up on entry; on the shortcut paths
  // (T==0, early out) DONE first publishes the result and raises done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (t_zero || early) ? DONE : CALC;
      CALC: if (count == CNT_ONE) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      signed_q <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      zero_q   <= 1'b0;
      s_raw    <= '0;
      dvs      <= '0;
      dvd      <= '0;
      rem      <= '0;
      count    <= '0;
      VY_hi    <= '0;
      VY_lo    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div0     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            signed_q <= is_signed;
            sign_q   <= is_signed && (S[WIDTH-1] ^ T[WIDTH-1]);
            sign_r   <= is_signed && S[WIDTH-1];
            zero_q   <= t_zero;
            s_raw    <= S;
            dvs      <= t_mag;
            dvd      <= s_mag;
            rem      <= '0;
            count    <= CNT_INIT;
            busy     <= 1'b1;
            div0     <= 1'b0;
          end
        end
        CALC: begin
          rem   <= step_rem;
          dvd   <= step_dvd | {{(WIDTH-1){1'b0}}, step_q};
          count <= count - CNT_ONE;
        end
        FIX: begin
          VY_lo <= (signed_q && sign_q) ? (~dvd + ONE) : dvd;
          VY_hi <= (signed_q && sign_r) ? (~rem + ONE) : rem;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          if (!done) begin
            // Shortcut completion: divide-by-zero or early out.
            VY_lo <= zero_q ? ALL_ONES : '0;
            VY_hi <= s_raw;
            div0  <= zero_q;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            done  <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_div_8_seq.sv
module tb_div_8_seq;
  import div_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] S;
  logic [7:0] T;
  logic [4:0] FS;
  logic [7:0] VY_hi;
  logic [7:0] VY_lo;
  logic       busy;
  logic       done;
  logic       div0;
  state_t     dbg_state;

  always #5 clk = ~clk;

  div_8_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .S         (S),
    .T         (T),
    .FS        (FS),
    .VY_hi     (VY_hi),
    .VY_lo     (VY_lo),
    .busy      (busy),
    .done      (done),
    .div0      (div0),
    .dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

`ifdef DIV8_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = 9;
`endif

  typedef struct {
    logic [7:0] s;
    logic [7:0] t;
    logic [4:0] fs;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  // Issues one request and waits (bounded) for done. lat = edges after the
  // accept edge at which done rose, -1 on timeout. Returns at the negedge
  // of the done cycle. Operands are scrambled after accept.
  task automatic run_div(input logic [7:0] s, input logic [7:0] t,
                         input logic [4:0] fs, output int lat,
                         output int busy_cyc);
    @(negedge clk);
    S = s; T = t; FS = fs; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    S = 8'($urandom_range(0, 255));
    T = 8'($urandom_range(0, 255));
    FS = 5'($urandom_range(0, 31));
    lat = -1;
    busy_cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i - 1;
        break;
      end
      if (busy) busy_cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; start = 1'b1; S = 8'h12; T = 8'h03; FS = 5'h4;
    repeat (3) @(negedge clk);
    checks++;
    if ({VY_hi, VY_lo, busy, done, div0} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got hi=%h lo=%h busy=%b done=%b div0=%b exp all 0",
               VY_hi, VY_lo, busy, done, div0);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divides();
    int lat;
    int bc;
    vecs.push_back('{8'd200, 8'd7,   5'h4, 8'h1C, 8'h04, 1'b0, 9});
    vecs.push_back('{8'hF9,  8'h02,  5'h3, 8'hFD, 8'hFF, 1'b0, 9});
    vecs.push_back('{8'h55,  8'h00,  5'h3, 8'hFF, 8'h55, 1'b1, 1});
    vecs.push_back('{8'd9,   8'd3,   5'h3, 8'h03, 8'h00, 1'b0, 9});
    vecs.push_back('{8'h80,  8'hFF,  5'h3, 8'h80, 8'h00, 1'b0, 9});
    vecs.push_back('{8'hFF,  8'h10,  5'h4, 8'h0F, 8'h0F, 1'b0, 9});
    vecs.push_back('{8'h07,  8'hFE,  5'h3, 8'hFD, 8'h01, 1'b0, 9});
    vecs.push_back('{8'hFF,  8'hFF,  5'h4, 8'h01, 8'h00, 1'b0, 9});
    vecs.push_back('{8'h80,  8'h00,  5'h4, 8'hFF, 8'h80, 1'b1, 1});
    vecs.push_back('{8'd3,   8'd10,  5'h4, 8'h00, 8'h03, 1'b0, EO_LAT});
    vecs.push_back('{8'hFD,  8'h0A,  5'h3, 8'h00, 8'hFD, 1'b0, EO_LAT});
    foreach (vecs[k]) begin
      run_div(vecs[k].s, vecs[k].t, vecs[k].fs, lat, bc);
      checks++;
      if (lat != vecs[k].lat) begin
        failures++;
        $display("FAIL latency[%0d] got=%0d exp=%0d", k, lat, vecs[k].lat);
      end
      checks++;
      if (VY_lo !== vecs[k].lo || VY_hi !== vecs[k].hi) begin
        failures++;
        $display("FAIL result[%0d] %h/%h fs=%h got lo=%h hi=%h exp lo=%h hi=%h",
                 k, vecs[k].s, vecs[k].t, vecs[k].fs, VY_lo, VY_hi, vecs[k].lo, vecs[k].hi);
      end
      checks++;
      if (div0 !== vecs[k].dz) begin
        failures++;
        $display("FAIL div0[%0d] got=%b exp=%b", k, div0, vecs[k].dz);
      end
      checks++;
      if (bc != vecs[k].lat || busy !== 1'b0) begin
        failures++;
        $display("FAIL busy[%0d] got cycles=%0d busy_at_done=%b exp cycles=%0d busy_at_done=0",
                 k, bc, busy, vecs[k].lat);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || VY_lo !== vecs[k].lo || VY_hi !== vecs[k].hi) begin
        failures++;
        $display("FAIL after_done[%0d] got done=%b lo=%h hi=%h exp done=0 lo=%h hi=%h",
                 k, done, VY_lo, VY_hi, vecs[k].lo, vecs[k].hi);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk);
    S = 8'd200; T = 8'd7; FS = 5'h4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);          // in CALC, iteration 4 pending
    reset = 1'b0;
    #1;
    checks++;
    if ({VY_hi, VY_lo, busy, done, div0} !== 19'd0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_mid_outputs got hi=%h lo=%h busy=%b done=%b div0=%b state=%0d exp all 0",
               VY_hi, VY_lo, busy, done, div0, dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_done got dones=%0d busy=%b exp 0 0", dones, busy);
    end
  endtask

  task automatic test_start_held();
    int dones = 0;
    @(negedge clk);
    S = 8'd100; T = 8'd10; FS = 5'h4; start = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 2) begin S = 8'd77; T = 8'd5; end
      if (done) begin
        dones++;
        checks++;
        if (VY_lo !== 8'h0A || VY_hi !== 8'h00) begin
          failures++;
          $display("FAIL start_held_result got lo=%h hi=%h exp lo=0a hi=00", VY_lo, VY_hi);
        end
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL start_held_dones got=%0d exp=1", dones);
    end
  endtask

  task automatic test_bad_fs();
    int bc = 0;
    int dones = 0;
    @(negedge clk);
    S = 8'd50; T = 8'd5; FS = 5'h2; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dones++;
    end
    start = 1'b0;
    checks++;
    if (bc != 0 || dones != 0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL bad_fs got busy_cycles=%0d dones=%0d state=%0d exp 0 0 IDLE",
               bc, dones, dbg_state);
    end
    checks++;
    if (VY_lo !== 8'h0A || VY_hi !== 8'h00) begin
      failures++;
      $display("FAIL bad_fs_hold got lo=%h hi=%h exp lo=0a hi=00", VY_lo, VY_hi);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0; start = 1'b0; S = '0; T = '0; FS = '0;
    test_reset();
    test_divides();
    test_reset_mid();
    test_start_held();
    test_bad_fs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
